// File: rtl/debouncer_bank.sv
// Multi-channel button/switch debouncer: synchroniser, stability filter, press/release pulses and long-press/auto-repeat.
// Pulses are registered, last one cycle and coincide with the debounced level change; no backpressure.
module debouncer_bank #(
  parameter int p_channels      = 4,
  parameter int p_sync_stages   = 2,
  parameter int p_counter_width = 4,
  parameter int p_stable_count  = 8,
  parameter int p_hold_width    = 8,
  parameter int p_hold_count    = 200,
  parameter int p_repeat_count  = 50,
  parameter int p_active_low    = 0
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_reset,
  input  logic                  i_w_tick,
  input  logic [p_channels-1:0] i_w_in,
  output logic [p_channels-1:0] o_w_state,
  output logic [p_channels-1:0] o_w_press,
  output logic [p_channels-1:0] o_w_release,
  output logic [p_channels-1:0] o_w_repeat
);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_REPEATING, ST_DONE} hold_st_t;

  localparam logic                       lp_idle_lvl   = (p_active_low != 0);
  localparam logic [p_counter_width-1:0] lp_stable_max = p_counter_width'(p_stable_count - 1);
  localparam logic [p_counter_width-1:0] lp_cnt_one    = p_counter_width'(1);
  localparam logic [p_hold_width-1:0]    lp_hold_max   = p_hold_width'(p_hold_count - 1);
  localparam logic [p_hold_width-1:0]    lp_rep_max    = p_hold_width'(p_repeat_count - 1);
  localparam logic [p_hold_width-1:0]    lp_hold_one   = p_hold_width'(1);

  if (p_channels < 1 || p_sync_stages < 2 ||
      p_stable_count < 1 || p_stable_count > (1 << p_counter_width) - 1 ||
      p_hold_count < 1 || p_hold_count > (1 << p_hold_width) - 1 ||
      p_repeat_count < 0 || p_repeat_count > (1 << p_hold_width) - 1) begin : g_bad_params
    $error("debouncer_bank: parameter out of legal range");
  end

  genvar g;
  generate
    for (g = 0; g < p_channels; g++) begin : g_ch
      logic [p_sync_stages-1:0]   r_sync;
      logic                       r_state, r_press, r_release, r_repeat;
      logic [p_counter_width-1:0] r_cnt, w_cnt_nxt;
      logic [p_hold_width-1:0]    r_hcnt, w_hcnt_nxt;
      hold_st_t                   r_hst, w_hst_nxt;
      logic                       w_norm, w_state_nxt, w_rise, w_fall, w_rep;

      // Sync flops idle at the inactive pin level so the normalised level reads 0 out of reset.
      always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) r_sync <= {p_sync_stages{lp_idle_lvl}};
        else           r_sync <= {r_sync[p_sync_stages-2:0], i_w_in[g]};
      end

      assign w_norm = r_sync[p_sync_stages-1] ^ lp_idle_lvl;

      always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        if (i_w_tick) begin
          if (w_norm == r_state) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == lp_stable_max) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ~r_state;
            w_rise      = ~r_state;
            w_fall      = r_state;
          end else begin
            w_cnt_nxt = r_cnt + lp_cnt_one;
          end
        end
      end

      // Release is checked first so it beats a coincident hold/repeat threshold.
      always_comb begin
        w_hst_nxt  = r_hst;
        w_hcnt_nxt = r_hcnt;
        w_rep      = 1'b0;
        if (w_fall) begin
          w_hst_nxt  = ST_IDLE;
          w_hcnt_nxt = '0;
        end else if (w_rise) begin
          w_hst_nxt  = ST_PRESSED;
          w_hcnt_nxt = '0;
        end else if (i_w_tick) begin
          case (r_hst)
            ST_PRESSED: begin
              if (r_hcnt == lp_hold_max) begin
                w_rep      = 1'b1;
                w_hcnt_nxt = '0;
                w_hst_nxt  = (p_repeat_count > 0) ? ST_REPEATING : ST_DONE;
              end else begin
                w_hcnt_nxt = r_hcnt + lp_hold_one;
              end
            end
            ST_REPEATING: begin
              if (r_hcnt == lp_rep_max) begin
                w_rep      = 1'b1;
                w_hcnt_nxt = '0;
              end else begin
                w_hcnt_nxt = r_hcnt + lp_hold_one;
              end
            end
            default: ;
          endcase
        end
      end

      always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
          r_state   <= 1'b0;
          r_cnt     <= '0;
          r_press   <= 1'b0;
          r_release <= 1'b0;
          r_repeat  <= 1'b0;
          r_hcnt    <= '0;
          r_hst     <= ST_IDLE;
        end else begin
          r_state   <= w_state_nxt;
          r_cnt     <= w_cnt_nxt;
          r_press   <= w_rise;
          r_release <= w_fall;
          r_repeat  <= w_rep;
          r_hcnt    <= w_hcnt_nxt;
          r_hst     <= w_hst_nxt;
        end
      end

      assign o_w_state[g]   = r_state;
      assign o_w_press[g]   = r_press;
      assign o_w_release[g] = r_release;
      assign o_w_repeat[g]  = r_repeat;
    end
  endgenerate

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed bench for debouncer_bank; a second instance is built with auto-repeat disabled.
module tb_debouncer_bank;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] din;
  logic [3:0] state, press, rel, rep;
  logic [3:0] state0, press0, rel0, rep0;

  int n_vec  = 0;
  int n_miss = 0;

  debouncer_bank #(
    .p_channels(4), .p_sync_stages(2), .p_counter_width(4), .p_stable_count(4),
    .p_hold_width(8), .p_hold_count(10), .p_repeat_count(3), .p_active_low(0)
  ) u_dut (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_tick(tick), .i_w_in(din),
    .o_w_state(state), .o_w_press(press), .o_w_release(rel), .o_w_repeat(rep)
  );

  debouncer_bank #(
    .p_channels(4), .p_sync_stages(2), .p_counter_width(4), .p_stable_count(4),
    .p_hold_width(8), .p_hold_count(10), .p_repeat_count(0), .p_active_low(0)
  ) u_dut_norep (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_tick(tick), .i_w_in(din),
    .o_w_state(state0), .o_w_press(press0), .o_w_release(rel0), .o_w_repeat(rep0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %b, expected %b", tag, got, want);
    end
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] want_rep, want_rep0, want_rel, want_st, want_pr;
    rst  = 1'b1;
    tick = 1'b1;
    din  = 4'b0000;
    edge_n(3);
    chk("rst_state", state, 4'b0000);
    chk("rst_press", press, 4'b0000);
    chk("rst_release", rel, 4'b0000);
    chk("rst_repeat", rep, 4'b0000);
    rst = 1'b0;
    edge_n(2);

    // Clean press on ch0, then a clean release
    din[0] = 1'b1;
    edge_n(5);
    chk("t1_state_e5", state, 4'b0000);
    edge_n(1);
    chk("t1_state_e6", state, 4'b0001);
    chk("t1_press_e6", press, 4'b0001);
    chk("t1_release_e6", rel, 4'b0000);
    edge_n(1);
    chk("t1_press_e7", press, 4'b0000);
    chk("t1_state_e7", state, 4'b0001);
    din[0] = 1'b0;
    edge_n(6);
    chk("t1_release", rel, 4'b0001);
    chk("t1_state_rel", state, 4'b0000);
    chk("t1_no_repeat", rep, 4'b0000);
    edge_n(1);
    chk("t1_release_gone", rel, 4'b0000);

    // Bounce on ch1
    din[1] = 1'b1; edge_n(1); chk("t2_bounce1", press, 4'b0000);
    din[1] = 1'b0; edge_n(1); chk("t2_bounce2", press, 4'b0000);
    din[1] = 1'b1; edge_n(1); chk("t2_bounce3", press, 4'b0000);
    din[1] = 1'b0; edge_n(1); chk("t2_bounce4", press, 4'b0000);
    din[1] = 1'b1;
    for (int k = 5; k <= 9; k++) begin
      edge_n(1);
      chk("t2_settle_press", press, 4'b0000);
      chk("t2_settle_state", state, 4'b0000);
    end
    edge_n(1);
    chk("t2_state", state, 4'b0010);
    chk("t2_press", press, 4'b0010);
    edge_n(1);
    chk("t2_press_gone", press, 4'b0000);
    din[1] = 1'b0;
    edge_n(8);
    chk("t2_released", state, 4'b0000);

    // Long press with repeats on ch2; release lands on a repeat slot
    din[2] = 1'b1;
    edge_n(6);
    chk("t3_press", press, 4'b0100);
    chk("t3_press_norep", press0, 4'b0100);
    for (int k = 1; k <= 52; k++) begin
      edge_n(1);
      want_rep  = (k >= 10 && k < 46 && (k - 10) % 3 == 0) ? 4'b0100 : 4'b0000;
      want_rep0 = (k == 10) ? 4'b0100 : 4'b0000;
      want_rel  = (k == 46) ? 4'b0100 : 4'b0000;
      chk("t3_repeat", rep, want_rep);
      chk("t3_repeat_norep", rep0, want_rep0);
      chk("t3_release", rel, want_rel);
      chk("t3_release_norep", rel0, want_rel);
      if (k == 40) din[2] = 1'b0;
    end

    // Release qualifies on the hold-threshold tick for ch1
    din[1] = 1'b1;
    edge_n(6);
    chk("t5_press", press, 4'b0010);
    edge_n(4);
    din[1] = 1'b0;
    edge_n(5);
    chk("t5_state_e9", state, 4'b0010);
    chk("t5_repeat_e9", rep, 4'b0000);
    edge_n(1);
    chk("t5_release", rel, 4'b0010);
    chk("t5_repeat", rep, 4'b0000);
    chk("t5_repeat_norep", rep0, 4'b0000);
    chk("t5_state", state, 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      edge_n(1);
      chk("t5_idle_repeat", rep, 4'b0000);
    end

    // Tick every 4th cycle, clean step on ch3
    tick   = 1'b0;
    din[3] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      edge_n(1);
      want_pr = (c == 16) ? 4'b1000 : 4'b0000;
      want_st = (c >= 16) ? 4'b1000 : 4'b0000;
      chk("t4_press", press, want_pr);
      chk("t4_state", state, want_st);
      tick = ((c + 1) % 4 == 0);
    end
    tick   = 1'b1;
    din[3] = 1'b0;
    edge_n(6);
    chk("t4_release", rel, 4'b1000);
    chk("t4_repeat", rep, 4'b0000);

    // Async reset while ch0 is repeating
    din[0] = 1'b1;
    edge_n(6);
    chk("t6_press", press, 4'b0001);
    edge_n(13);
    chk("t6_repeat_e13", rep, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_state", state, 4'b0000);
    chk("t6_rst_press", press, 4'b0000);
    chk("t6_rst_release", rel, 4'b0000);
    chk("t6_rst_repeat", rep, 4'b0000);
    chk("t6_rst_state_norep", state0, 4'b0000);
    edge_n(1);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      edge_n(1);
      chk("t6_post_state", state, 4'b0000);
      chk("t6_post_press", press, 4'b0000);
      chk("t6_post_release", rel, 4'b0000);
      chk("t6_post_repeat", rep, 4'b0000);
    end
    edge_n(1);
    chk("t6_repress_state", state, 4'b0001);
    chk("t6_repress_press", press, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/debouncer_bank.md
Name: debouncer_bank

Overview:
Multi-channel parametrised debouncer for push-buttons and switches. Each channel has its own:
- synchroniser
- stability filter with a programmable threshold
- one-cycle press and release pulses
- long-press / auto-repeat state machine

An optional sample strobe lets one shared prescaler slow all filters. The block sits between board pins and the user-input logic (menus, counters, FSM stimulus).

Parameters:
p_channels, 4, number of independent input channels (>=1).
p_sync_stages, 2, synchroniser flops per channel (>=2).
p_counter_width, 4, width of the per-channel stability counter.
p_stable_count, 8, consecutive mismatching tick samples required to toggle; legal range 1..2^p_counter_width-1.
p_hold_width, 8, width of the per-channel hold/repeat counter.
p_hold_count, 200, ticks the debounced level must stay 1 before the first repeat pulse; legal range 1..2^p_hold_width-1.
p_repeat_count, 50, ticks between subsequent repeat pulses; 0 = single long-press pulse only, no auto-repeat.
p_active_low, 0, 1 = raw inputs are active-low and are inverted after the synchroniser.

Ports:
i_w_clk  input  1  system clock, all state on rising edge.
i_w_reset  input  1  asynchronous, active-high reset.
i_w_tick  input  1  sample strobe; filter and hold logic advance only when 1; tie to 1 for per-cycle sampling.
i_w_in  input  p_channels  raw asynchronous inputs, one bit per channel.
o_w_state  output  p_channels  debounced, normalised (1 = active) level.
o_w_press  output  p_channels  one-cycle pulse when o_w_state rises.
o_w_release  output  p_channels  one-cycle pulse when o_w_state falls.
o_w_repeat  output  p_channels  one-cycle pulse on long-press and on each auto-repeat.

Behaviour:
- Reset (asynchronous, active-high): all outputs, counters and FSMs go to 0/IDLE. Sync flops reset to p_active_low, so the normalised level reads 0.
- Synchroniser: runs every cycle, independent of i_w_tick. Normalised value n = sync_out XOR p_active_low.
- Non-tick cycles: filter, hold counter, FSM and o_w_state hold their values. All pulse outputs are 0.
- Filter (on tick):
  - If n == o_w_state: counter is cleared to 0.
  - Else if counter == p_stable_count-1: o_w_state toggles, counter is cleared, and o_w_press or o_w_release asserts for that one cycle (registered, coincident with the state change).
  - Else: counter increments.
  - Any matching sample restarts qualification.
- Latency with i_w_tick=1: raw step between edges 0 and 1 -> o_w_state and press/release change at edge p_sync_stages+p_stable_count.
- Hold FSM per channel, states IDLE, PRESSED, REPEATING, DONE:
  - IDLE -> PRESSED on the press toggle; hold counter cleared.
  - PRESSED, on tick: counter increments. When counter == p_hold_count-1: o_w_repeat pulses, counter is cleared, next state is REPEATING (p_repeat_count>0) or DONE (p_repeat_count==0).
  - REPEATING, on tick: counter increments. When counter == p_repeat_count-1: o_w_repeat pulses and counter is cleared; stays in REPEATING.
  - Any state -> IDLE on the release toggle; counter cleared; no repeat pulse in that cycle.
  - Timing: first repeat pulse occurs exactly p_hold_count ticks after the press pulse; subsequent pulses every p_repeat_count ticks.
- Simultaneous events:
  - Release toggle and hold/repeat threshold on the same tick: release wins, o_w_repeat stays 0.
  - Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.
- Counter overflow cannot occur within legal parameter ranges. Out-of-range parameters are an elaboration error (generate-time check).
- Reset mid-operation: immediate return to reset values. Any pulse in flight is dropped; no pulse is produced on reset deassertion.
- Output pulse vectors are per-bit independent; never held for more than one cycle.

Test Plan:
Bench parameters: p_channels=4, p_sync_stages=2, p_stable_count=4, p_hold_count=10, p_repeat_count=3, p_active_low=0, i_w_tick=1 unless stated.
1. Clean press: i_w_in[0] 0->1 before edge 1 and held -> o_w_state[0]=1 and o_w_press[0]=1 for exactly one cycle at edge 6; other channels stay 0.
2. Bounce: i_w_in[1] toggles 1,0,1,0 on consecutive cycles, then stays 1 -> no toggle during bouncing; o_w_state[1] rises 6 edges after the final rising transition; single press pulse.
3. Long press and repeat: ch2 held 40 cycles after press at edge E -> o_w_repeat[2] at E+10, E+13, E+16, ...; release -> one release pulse, no further repeats. Rerun with p_repeat_count=0 -> exactly one o_w_repeat at E+10.
4. Tick gating: i_w_tick=1 every 4th cycle, clean step on ch3 -> toggle after 4 tick samples; all pulses coincide with tick cycles.
5. Race: release qualifies on the same tick as the hold threshold -> o_w_release=1, o_w_repeat=0, FSM returns to IDLE.
6. Async reset mid-hold: assert i_w_reset between clock edges while ch0 is REPEATING -> all outputs 0 immediately. Deassert with input still 1 -> a fresh press qualifies after 6 edges.
